// File: rtl/pe_pad_sequencer.sv
// pe_pad_sequencer
//
// Per-PE control sequencer. For one configured tile it walks the convolution
// loop nest (outer to inner: pixel ow, filter row r, channel c, filter m)
// and issues one MAC control beat per accepted handshake. Each beat carries
// the ipad/wpad/ppad addresses and the psum first/last flags.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           one-cycle pulse: check and latch cfg_* and begin a tile
//   cfg_pch/pm/r/u/tw  tile configuration (Pch, Pm, R, U, Tw)
//   out_vld/out_rdy beat handshake towards the datapath fetch stage
//   ip_raddr        ipad read address  ((base + r*pch + c) mod IPADSIZE)
//   wp_raddr        wpad read address  ((r*pch + c)*pm + m)
//   pp_addr         ppad address (= m)
//   fstrow          first (r,c) of the pixel: psum starts from zero
//   lstrow          last (r,c) of the pixel: psum is written out
//   lastpix         beat belongs to pixel Tw-1
//   busy            tile in progress
//   done            one-cycle pulse after the final beat was accepted
//   cfg_err         one-cycle pulse: start rejected because of illegal config
//
// States:
//   S_IDLE | waiting for start, config checked on start
//   S_RUN  | issuing beats, counters advance on out_vld && out_rdy
//   S_DONE | one-cycle done pulse, then back to S_IDLE

module pe_pad_sequencer #(
  parameter int IPADSIZE   = 12,
  parameter int WPADSIZE   = 48,
  parameter int PPADSIZE   = 64,
  parameter int IPADADDRWD = $clog2(IPADSIZE),
  parameter int WPADADDRWD = $clog2(WPADSIZE),
  parameter int PPADADDRWD = $clog2(PPADSIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0]            cfg_pch,
  input  logic [4:0]            cfg_pm,
  input  logic [3:0]            cfg_r,
  input  logic [2:0]            cfg_u,
  input  logic [6:0]            cfg_tw,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [IPADADDRWD-1:0] ip_raddr,
  output logic [WPADADDRWD-1:0] wp_raddr,
  output logic [PPADADDRWD-1:0] pp_addr,
  output logic                  fstrow,
  output logic                  lstrow,
  output logic                  lastpix,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  // One extra bit so a pixel step of exactly IPADSIZE fits, and two extra
  // bits for the base + step sum before the modulo subtract.
  localparam int STEPW = IPADADDRWD + 1;
  localparam int SUMW  = IPADADDRWD + 2;
  localparam logic [STEPW-1:0] IPSZ_S = STEPW'(IPADSIZE);
  localparam logic [SUMW-1:0]  IPSZ_B = SUMW'(IPADSIZE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // latched configuration
  logic [3:0]            cpch_q, cpch_d;
  logic [4:0]            cpm_q,  cpm_d;
  logic [3:0]            cr_q,   cr_d;
  logic [6:0]            ctw_q,  ctw_d;
  logic [STEPW-1:0]      step_q, step_d;

  // loop counters and address state
  logic [4:0]            m_q,    m_d;
  logic [3:0]            c_q,    c_d;
  logic [3:0]            r_q,    r_d;
  logic [6:0]            ow_q,   ow_d;
  logic [IPADADDRWD-1:0] base_q, base_d;
  logic [IPADADDRWD-1:0] ip_q,   ip_d;
  logic [WPADADDRWD-1:0] wp_q,   wp_d;

  logic                  fst_q,  fst_d;
  logic                  lst_q,  lst_d;
  logic                  lpx_q,  lpx_d;
  logic                  err_q,  err_d;

  // ---------------------------------------------------------------------
  // Config legality check (only evaluated on a start in IDLE)
  // ---------------------------------------------------------------------
  logic [15:0] prod_cr, prod_cmr, prod_uc;
  logic        cfg_bad;

  always_comb begin
    prod_cr  = 16'(cfg_pch) * 16'(cfg_r);
    prod_cmr = prod_cr * 16'(cfg_pm);
    prod_uc  = 16'(cfg_u) * 16'(cfg_pch);
    cfg_bad  = (cfg_pch == 4'd0) || (cfg_pm == 5'd0) || (cfg_r == 4'd0) ||
               (cfg_u == 3'd0) || (cfg_tw == 7'd0) ||
               (prod_cr  > 16'(IPADSIZE)) ||
               (prod_cmr > 16'(WPADSIZE)) ||
               (16'(cfg_pm) > 16'(PPADSIZE)) ||
               (prod_uc  > 16'(IPADSIZE));
  end

  // ---------------------------------------------------------------------
  // Modulo helpers: both sums stay below 2*IPADSIZE, so one conditional
  // subtract is enough.
  // ---------------------------------------------------------------------
  logic [STEPW-1:0]      ip_inc;
  logic [IPADADDRWD-1:0] ip_next;
  logic [SUMW-1:0]       base_sum;
  logic [IPADADDRWD-1:0] base_next;

  always_comb begin
    ip_inc = {1'b0, ip_q} + STEPW'(1);
    if (ip_inc >= IPSZ_S) begin
      ip_inc = ip_inc - IPSZ_S;
    end
    ip_next = ip_inc[IPADADDRWD-1:0];

    base_sum = {2'b00, base_q} + {1'b0, step_q};
    if (base_sum >= IPSZ_B) begin
      base_sum = base_sum - IPSZ_B;
    end
    base_next = base_sum[IPADADDRWD-1:0];
  end

  // ---------------------------------------------------------------------
  // Last-index compares on the current counters
  // ---------------------------------------------------------------------
  logic last_m, last_c, last_r, last_ow;

  always_comb begin
    last_m  = (m_q  == cpm_q  - 5'd1);
    last_c  = (c_q  == cpch_q - 4'd1);
    last_r  = (r_q  == cr_q   - 4'd1);
    last_ow = (ow_q == ctw_q  - 7'd1);
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cpch_d  = cpch_q;
    cpm_d   = cpm_q;
    cr_d    = cr_q;
    ctw_d   = ctw_q;
    step_d  = step_q;
    m_d     = m_q;
    c_d     = c_q;
    r_d     = r_q;
    ow_d    = ow_q;
    base_d  = base_q;
    ip_d    = ip_q;
    wp_d    = wp_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            err_d = 1'b1;
          end else begin
            cpch_d  = cfg_pch;
            cpm_d   = cfg_pm;
            cr_d    = cfg_r;
            ctw_d   = cfg_tw;
            step_d  = STEPW'(prod_uc);
            m_d     = '0;
            c_d     = '0;
            r_d     = '0;
            ow_d    = '0;
            base_d  = '0;
            ip_d    = '0;
            wp_d    = '0;
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (out_rdy) begin
          // wp_raddr is the beat index within the pixel, and ip offset
          // (r*pch + c) moves by one on every (r,c) step, so both are
          // plain increments with a reset at the pixel boundary.
          if (!last_m) begin
            m_d  = m_q + 5'd1;
            wp_d = wp_q + WPADADDRWD'(1);
          end else begin
            m_d = '0;
            if (!last_c) begin
              c_d  = c_q + 4'd1;
              ip_d = ip_next;
              wp_d = wp_q + WPADADDRWD'(1);
            end else begin
              c_d = '0;
              if (!last_r) begin
                r_d  = r_q + 4'd1;
                ip_d = ip_next;
                wp_d = wp_q + WPADADDRWD'(1);
              end else begin
                r_d  = '0;
                wp_d = '0;
                if (!last_ow) begin
                  ow_d   = ow_q + 7'd1;
                  base_d = base_next;
                  ip_d   = base_next;
                end else begin
                  state_d = S_DONE;
                end
              end
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Flags are registered from the next counter values so the outputs
    // come straight from flops.
    fst_d = (r_d == 4'd0) && (c_d == 4'd0);
    lst_d = (r_d == cr_d - 4'd1) && (c_d == cpch_d - 4'd1);
    lpx_d = (ow_d == ctw_d - 7'd1);
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cpch_q  <= '0;
      cpm_q   <= '0;
      cr_q    <= '0;
      ctw_q   <= '0;
      step_q  <= '0;
      m_q     <= '0;
      c_q     <= '0;
      r_q     <= '0;
      ow_q    <= '0;
      base_q  <= '0;
      ip_q    <= '0;
      wp_q    <= '0;
      fst_q   <= 1'b0;
      lst_q   <= 1'b0;
      lpx_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cpch_q  <= cpch_d;
      cpm_q   <= cpm_d;
      cr_q    <= cr_d;
      ctw_q   <= ctw_d;
      step_q  <= step_d;
      m_q     <= m_d;
      c_q     <= c_d;
      r_q     <= r_d;
      ow_q    <= ow_d;
      base_q  <= base_d;
      ip_q    <= ip_d;
      wp_q    <= wp_d;
      fst_q   <= fst_d;
      lst_q   <= lst_d;
      lpx_q   <= lpx_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: beat fields are forced to zero outside RUN so IDLE/DONE
  // present an all-zero bus regardless of leftover counter values.
  // ---------------------------------------------------------------------
  logic run;

  always_comb begin
    run      = (state_q == S_RUN);
    out_vld  = run;
    busy     = run;
    done     = (state_q == S_DONE);
    cfg_err  = err_q;
    ip_raddr = run ? ip_q : '0;
    wp_raddr = run ? wp_q : '0;
    pp_addr  = run ? PPADADDRWD'(m_q) : '0;
    fstrow   = run & fst_q;
    lstrow   = run & lst_q;
    lastpix  = run & lpx_q;
  end

endmodule

// File: tb/tb_pe_pad_sequencer.sv
module tb_pe_pad_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] cfg_pch;
  logic [4:0] cfg_pm;
  logic [3:0] cfg_r;
  logic [2:0] cfg_u;
  logic [6:0] cfg_tw;
  logic       out_vld;
  logic       out_rdy;
  logic [3:0] ip_raddr;
  logic [5:0] wp_raddr;
  logic [5:0] pp_addr;
  logic       fstrow, lstrow, lastpix, busy, done, cfg_err;

  pe_pad_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cfg_pch  (cfg_pch),
    .cfg_pm   (cfg_pm),
    .cfg_r    (cfg_r),
    .cfg_u    (cfg_u),
    .cfg_tw   (cfg_tw),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .ip_raddr (ip_raddr),
    .wp_raddr (wp_raddr),
    .pp_addr  (pp_addr),
    .fstrow   (fstrow),
    .lstrow   (lstrow),
    .lastpix  (lastpix),
    .busy     (busy),
    .done     (done),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0] ip_log  [64];
  logic [5:0] wp_log  [64];
  logic [5:0] pp_log  [64];
  logic       fst_log [64];
  logic       lst_log [64];
  logic       lpx_log [64];
  int n_beats, done_cnt, done_cyc, last_acc, stall_viol, vld_in_done;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int pch, input int pm, input int r,
                             input int u, input int tw);
    cfg_pch = 4'(pch);
    cfg_pm  = 5'(pm);
    cfg_r   = 4'(r);
    cfg_u   = 3'(u);
    cfg_tw  = 7'(tw);
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  // Runs the handshake from the current cycle until done (or the budget
  // expires), logging every accepted beat. mode 0: out_rdy always 1;
  // mode 1: out_rdy pattern 1,0,0 repeating. stray_at >= 0 pulses a start
  // with a different config in that cycle.
  task automatic collect(input int mode, input int stray_at, input int maxcyc);
    logic       rdy;
    logic       prev_stall;
    logic [19:0] snap;
    n_beats     = 0;
    done_cnt    = 0;
    done_cyc    = -1;
    last_acc    = -1;
    stall_viol  = 0;
    vld_in_done = 0;
    prev_stall  = 1'b0;
    snap        = '0;
    for (int cyc = 0; cyc < maxcyc; cyc++) begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (out_vld) vld_in_done++;
      end
      if (prev_stall &&
          ({ip_raddr, wp_raddr, pp_addr, fstrow, lstrow, lastpix, out_vld} !== snap))
        stall_viol++;
      if (stray_at >= 0) begin
        if (cyc == stray_at) begin
          cfg_pch = 4'd2;
          cfg_tw  = 7'd5;
          start   = 1'b1;
        end else begin
          start = 1'b0;
        end
      end
      rdy = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      out_rdy = rdy;
      if (out_vld && rdy && n_beats < 64) begin
        ip_log[n_beats]  = ip_raddr;
        wp_log[n_beats]  = wp_raddr;
        pp_log[n_beats]  = pp_addr;
        fst_log[n_beats] = fstrow;
        lst_log[n_beats] = lstrow;
        lpx_log[n_beats] = lastpix;
        n_beats++;
        last_acc = cyc;
      end
      prev_stall = out_vld && !rdy;
      snap = {ip_raddr, wp_raddr, pp_addr, fstrow, lstrow, lastpix, out_vld};
      if (done_cnt > 0 && cyc >= done_cyc + 2) break;
      tick();
    end
    start   = 1'b0;
    out_rdy = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; out_rdy = 1'b1;
    cfg_pch = '0; cfg_pm = '0; cfg_r = '0; cfg_u = '0; cfg_tw = '0;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({out_vld, busy, done, cfg_err, fstrow, lstrow, lastpix} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0000000",
               {out_vld, busy, done, cfg_err, fstrow, lstrow, lastpix});
    end
    checks++;
    if ({ip_raddr, wp_raddr, pp_addr} !== 16'h0) begin
      errors++;
      $display("FAIL reset_addr got %h want 0000", {ip_raddr, wp_raddr, pp_addr});
    end
  endtask

  task automatic test_basic_walk();
    int e_ip[6], e_wp[6], e_fst[6], e_lst[6], e_lpx[6];
    e_ip  = '{0, 1, 2, 1, 2, 3};
    e_wp  = '{0, 1, 2, 0, 1, 2};
    e_fst = '{1, 0, 0, 1, 0, 0};
    e_lst = '{0, 0, 1, 0, 0, 1};
    e_lpx = '{0, 0, 0, 1, 1, 1};
    pulse_start(1, 1, 3, 1, 2);
    checks++;
    if (out_vld !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_first_vld got vld=%b busy=%b want 1 1", out_vld, busy);
    end
    collect(0, -1, 50);
    checks++;
    if (n_beats != 6) begin
      errors++;
      $display("FAIL basic_beats got %0d want 6", n_beats);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (ip_log[i] !== 4'(e_ip[i]) || wp_log[i] !== 6'(e_wp[i]) || pp_log[i] !== 6'd0) begin
        errors++;
        $display("FAIL basic_addr beat %0d got ip=%0d wp=%0d pp=%0d want ip=%0d wp=%0d pp=0",
                 i, ip_log[i], wp_log[i], pp_log[i], e_ip[i], e_wp[i]);
      end
      checks++;
      if ({fst_log[i], lst_log[i], lpx_log[i]} !== {1'(e_fst[i]), 1'(e_lst[i]), 1'(e_lpx[i])}) begin
        errors++;
        $display("FAIL basic_flags beat %0d got %b%b%b want %0d%0d%0d",
                 i, fst_log[i], lst_log[i], lpx_log[i], e_fst[i], e_lst[i], e_lpx[i]);
      end
    end
    checks++;
    if (done_cnt != 1 || done_cyc != last_acc + 1 || vld_in_done != 0) begin
      errors++;
      $display("FAIL basic_done got cnt=%0d cyc=%0d last=%0d vld=%0d want cnt=1 cyc=last+1 vld=0",
               done_cnt, done_cyc, last_acc, vld_in_done);
    end
    checks++;
    if (out_vld !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle got vld=%b busy=%b done=%b want 0 0 0", out_vld, busy, done);
    end
  endtask

  task automatic test_ipad_wrap();
    int e_ip[24];
    e_ip = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11,
             4, 5, 6, 7, 8, 9, 10, 11, 0, 1, 2, 3};
    pulse_start(4, 1, 3, 1, 2);
    collect(0, -1, 100);
    checks++;
    if (n_beats != 24) begin
      errors++;
      $display("FAIL wrap_beats got %0d want 24", n_beats);
    end
    for (int i = 0; i < 24; i++) begin
      checks++;
      if (ip_log[i] !== 4'(e_ip[i]) || wp_log[i] !== 6'(i % 12)) begin
        errors++;
        $display("FAIL wrap_addr beat %0d got ip=%0d wp=%0d want ip=%0d wp=%0d",
                 i, ip_log[i], wp_log[i], e_ip[i], i % 12);
      end
    end
    checks++;
    if (fst_log[12] !== 1'b1 || lst_log[11] !== 1'b1 || lpx_log[11] !== 1'b0 ||
        lpx_log[12] !== 1'b1 || fst_log[5] !== 1'b0) begin
      errors++;
      $display("FAIL wrap_flags got fst12=%b lst11=%b lpx11=%b lpx12=%b fst5=%b want 1 1 0 1 0",
               fst_log[12], lst_log[11], lpx_log[11], lpx_log[12], fst_log[5]);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL wrap_done got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_filter_inner();
    int e_ip[6], e_pp[6], e_fst[6], e_lst[6];
    e_ip  = '{0, 0, 0, 1, 1, 1};
    e_pp  = '{0, 1, 2, 0, 1, 2};
    e_fst = '{1, 1, 1, 0, 0, 0};
    e_lst = '{0, 0, 0, 1, 1, 1};
    pulse_start(2, 3, 1, 1, 1);
    collect(0, -1, 50);
    checks++;
    if (n_beats != 6) begin
      errors++;
      $display("FAIL filt_beats got %0d want 6", n_beats);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (ip_log[i] !== 4'(e_ip[i]) || wp_log[i] !== 6'(i) || pp_log[i] !== 6'(e_pp[i])) begin
        errors++;
        $display("FAIL filt_addr beat %0d got ip=%0d wp=%0d pp=%0d want ip=%0d wp=%0d pp=%0d",
                 i, ip_log[i], wp_log[i], pp_log[i], e_ip[i], i, e_pp[i]);
      end
      checks++;
      if ({fst_log[i], lst_log[i], lpx_log[i]} !== {1'(e_fst[i]), 1'(e_lst[i]), 1'b1}) begin
        errors++;
        $display("FAIL filt_flags beat %0d got %b%b%b want %0d%0d1",
                 i, fst_log[i], lst_log[i], lpx_log[i], e_fst[i], e_lst[i]);
      end
    end
  endtask

  task automatic test_cfg_reject();
    int bad[4][5];
    bad = '{'{4, 4, 4, 1, 1},    // wpad 64 > 48
            '{1, 1, 3, 1, 0},    // tw = 0
            '{4, 1, 4, 1, 1},    // ipad pch*r 16 > 12
            '{4, 1, 1, 4, 1}};   // stride u*pch 16 > 12
    for (int k = 0; k < 4; k++) begin
      pulse_start(bad[k][0], bad[k][1], bad[k][2], bad[k][3], bad[k][4]);
      checks++;
      if (cfg_err !== 1'b1 || busy !== 1'b0 || out_vld !== 1'b0) begin
        errors++;
        $display("FAIL reject_%0d got err=%b busy=%b vld=%b want 1 0 0", k, cfg_err, busy, out_vld);
      end
      tick();
      checks++;
      if (cfg_err !== 1'b0 || busy !== 1'b0 || out_vld !== 1'b0) begin
        errors++;
        $display("FAIL reject_after_%0d got err=%b busy=%b vld=%b want 0 0 0", k, cfg_err, busy, out_vld);
      end
    end
  endtask

  task automatic test_backpressure();
    int e_ip[6], e_wp[6];
    e_ip = '{0, 1, 2, 1, 2, 3};
    e_wp = '{0, 1, 2, 0, 1, 2};
    pulse_start(1, 1, 3, 1, 2);
    collect(1, -1, 100);
    checks++;
    if (n_beats != 6) begin
      errors++;
      $display("FAIL bp_beats got %0d want 6", n_beats);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (ip_log[i] !== 4'(e_ip[i]) || wp_log[i] !== 6'(e_wp[i])) begin
        errors++;
        $display("FAIL bp_addr beat %0d got ip=%0d wp=%0d want ip=%0d wp=%0d",
                 i, ip_log[i], wp_log[i], e_ip[i], e_wp[i]);
      end
    end
    checks++;
    if (stall_viol != 0) begin
      errors++;
      $display("FAIL bp_stable got %0d changes while stalled want 0", stall_viol);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != 16) begin
      errors++;
      $display("FAIL bp_done got cnt=%0d cyc=%0d want cnt=1 cyc=16", done_cnt, done_cyc);
    end
  endtask

  task automatic test_reset_midrun();
    int dseen;
    out_rdy = 1'b1;
    pulse_start(1, 1, 3, 1, 2);
    tick();
    tick();
    tick();
    checks++;
    if (ip_raddr !== 4'd1 || fstrow !== 1'b1 || lastpix !== 1'b1) begin
      errors++;
      $display("FAIL mid_beat3 got ip=%0d fst=%b lpx=%b want ip=1 fst=1 lpx=1", ip_raddr, fstrow, lastpix);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({out_vld, busy, done, cfg_err, fstrow, lstrow, lastpix, ip_raddr, wp_raddr, pp_addr} !== 23'b0) begin
      errors++;
      $display("FAIL mid_reset got vld=%b busy=%b done=%b ip=%0d wp=%0d want all 0",
               out_vld, busy, done, ip_raddr, wp_raddr);
    end
    dseen = 0;
    for (int i = 0; i < 6; i++) begin
      if (done || out_vld) dseen++;
      tick();
    end
    checks++;
    if (dseen != 0) begin
      errors++;
      $display("FAIL mid_no_done got %0d active cycles want 0", dseen);
    end
    pulse_start(1, 1, 3, 1, 2);
    checks++;
    if (out_vld !== 1'b1 || ip_raddr !== 4'd0 || fstrow !== 1'b1) begin
      errors++;
      $display("FAIL mid_restart got vld=%b ip=%0d fst=%b want 1 0 1", out_vld, ip_raddr, fstrow);
    end
    collect(0, -1, 50);
    checks++;
    if (n_beats != 6 || ip_log[5] !== 4'd3) begin
      errors++;
      $display("FAIL mid_replay got beats=%0d last_ip=%0d want 6 3", n_beats, ip_log[5]);
    end
  endtask

  task automatic test_stray_start();
    int e_ip[6];
    e_ip = '{0, 1, 2, 1, 2, 3};
    pulse_start(1, 1, 3, 1, 2);
    collect(0, 2, 50);
    checks++;
    if (n_beats != 6 || done_cnt != 1) begin
      errors++;
      $display("FAIL stray_beats got beats=%0d done=%0d want 6 1", n_beats, done_cnt);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (ip_log[i] !== 4'(e_ip[i]) || lpx_log[i] !== (i >= 3)) begin
        errors++;
        $display("FAIL stray_addr beat %0d got ip=%0d lpx=%b want ip=%0d", i, ip_log[i], lpx_log[i], e_ip[i]);
      end
    end
    tick();
    checks++;
    if (out_vld !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stray_idle got vld=%b busy=%b want 0 0", out_vld, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic_walk();
    test_ipad_wrap();
    test_filter_inner();
    test_cfg_reject();
    test_backpressure();
    test_reset_midrun();
    test_stray_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
